// File: rtl/op_issue_scheduler.sv
// Operation issue scheduler: queues FHE operations from the host, issues them
// one at a time to the cpu and holds each until done, stalls on writeback
// hazards against the last retired op, drops NO_OPs and flags hung ops.

package op_issue_pkg;

    localparam int REG_NPOLY = 8;
    localparam int IDX_W     = $clog2(REG_NPOLY);

    typedef enum logic [2:0] {
        NO_OP     = 3'd0,
        CT_CT_ADD = 3'd1,
        CT_PT_ADD = 3'd2,
        CT_CT_MUL = 3'd3,
        CT_PT_MUL = 3'd4
    } op_mode_e;

    typedef struct packed {
        op_mode_e           mode;
        logic [IDX_W-1:0]   idx1_a;
        logic [IDX_W-1:0]   idx1_b;
        logic [IDX_W-1:0]   idx2_a;
        logic [IDX_W-1:0]   idx2_b;
        logic [IDX_W-1:0]   out_a;
        logic [IDX_W-1:0]   out_b;
    } operation;

endpackage

module op_issue_scheduler
    import op_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WB_GAP  = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  operation                   in_op,
    output logic                       in_ready,
    input  logic                       done_in,
    input  logic                       err_clr,
    output operation                   op_out,
    output logic                       busy,
    output logic                       err_timeout,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [CNT_W-1:0]           issued_cnt,
    output logic [CNT_W-1:0]           retired_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(WB_GAP + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    state_e             state_q, state_d;
    operation           fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   count_q;
    operation           op_reg_q;
    logic [TMR_W-1:0]   timer_q;
    logic [GAP_W-1:0]   gap_q;
    logic [IDX_W-1:0]   last_a_q, last_b_q;
    logic               err_q;
    logic [CNT_W-1:0]   issued_q, retired_q;

    logic               full, empty, push, pop;
    logic               issue_en, retire, timeout_hit, hazard;
    operation           head;

    assign full       = (count_q == OCC_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_count = count_q;
    assign issued_cnt  = issued_q;
    assign retired_cnt = retired_q;
    assign err_timeout = err_q;

    // A head op conflicts if any of its registers matches a dest of the op that just retired
    always_comb begin
        hazard = (head.idx1_a == last_a_q) || (head.idx1_a == last_b_q) ||
                 (head.idx1_b == last_a_q) || (head.idx1_b == last_b_q) ||
                 (head.idx2_a == last_a_q) || (head.idx2_a == last_b_q) ||
                 (head.idx2_b == last_a_q) || (head.idx2_b == last_b_q) ||
                 (head.out_a  == last_a_q) || (head.out_a  == last_b_q) ||
                 (head.out_b  == last_a_q) || (head.out_b  == last_b_q);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic plus the control strobes that drive the FIFO and datapath
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        issue_en    = 1'b0;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head.mode == NO_OP) begin
                        pop = 1'b1;
                    end else if (!(hazard && (gap_q != '0))) begin
                        pop      = 1'b1;
                        issue_en = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (done_in) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_ERROR;
                end
            end
            S_ERROR: begin
                if (err_clr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: the latched op is only visible to the cpu while it is in flight
    always_comb begin
        op_out = '0;
        busy   = 1'b0;
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            op_out = op_reg_q;
            busy   = 1'b1;
        end
    end

    // FIFO storage is not reset; only the pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_op;
    end

    // FIFO pointers and occupancy, push and pop may coincide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + OCC_W'(1);
            else if (pop && !push) count_q <= count_q - OCC_W'(1);
        end
    end

    // Datapath: in-flight op, watchdog timer, writeback gap, hazard tags, error flag, counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg_q  <= '0;
            timer_q   <= '0;
            gap_q     <= '0;
            last_a_q  <= '0;
            last_b_q  <= '0;
            err_q     <= 1'b0;
            issued_q  <= '0;
            retired_q <= '0;
        end else begin
            if (issue_en) begin
                op_reg_q <= head;
                issued_q <= issued_q + CNT_W'(1);
            end
            if (state_q == S_ISSUE) begin
                timer_q <= '0;
            end else if (state_q == S_WAIT && !done_in && timer_q != TMR_W'(TIMEOUT)) begin
                timer_q <= timer_q + TMR_W'(1);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
                last_a_q  <= op_reg_q.out_a;
                last_b_q  <= op_reg_q.out_b;
                gap_q     <= GAP_W'(WB_GAP);
            end else if (state_q == S_IDLE && gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (state_q == S_ERROR && err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule
